// File: rtl/thermo_seq_decoder.sv
// ============================================================================
// Module   : thermo_seq_decoder
// Purpose  : Multi-cycle thermometer-to-binary decoder; scans a latched W-bit
//            code one bit per cycle, reports the low run length and flags
//            bubbles. Optional macro THERMO_EARLY_EXIT_EN ends the scan once
//            no ones remain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thermo_seq_decoder #(
  parameter int K = 3,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] code,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] value,
  output logic         err
);

  localparam logic [K-1:0] c_LAST_IDX = K'(W - 1);
  localparam logic [K-1:0] c_MAX_CNT  = K'(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] shreg_q;
  logic [K-1:0] index_q;
  logic [K-1:0] count_q, count_d;
  logic         zero_seen_q, zero_seen_d;
  logic         bad_q, bad_d;
  logic         busy_q, done_q, err_q;
  logic [K-1:0] value_q;

  logic         w_cur_bit;
  logic         w_scan_exit;

  always_comb begin
    w_cur_bit   = shreg_q[index_q];
    count_d     = (w_cur_bit && !zero_seen_q && (count_q != c_MAX_CNT))
                  ? count_q + K'(1) : count_q;
    bad_d       = bad_q | (w_cur_bit & zero_seen_q);
    zero_seen_d = zero_seen_q | ~w_cur_bit;
`ifdef THERMO_EARLY_EXIT_EN
    // Current bit and everything above it zero: nothing left to count or flag.
    w_scan_exit = (index_q == c_LAST_IDX) || ((shreg_q >> index_q) == '0);
`else
    w_scan_exit = (index_q == c_LAST_IDX);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      index_q     <= '0;
      count_q     <= '0;
      zero_seen_q <= 1'b0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      value_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shreg_q     <= code;
            index_q     <= '0;
            count_q     <= '0;
            zero_seen_q <= 1'b0;
            bad_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_SCAN;
          end
        end
        S_SCAN: begin
          count_q     <= count_d;
          bad_q       <= bad_d;
          zero_seen_q <= zero_seen_d;
          index_q     <= index_q + K'(1);
          if (w_scan_exit) begin
            // Results are published from the final evaluation directly.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            value_q <= count_d;
            err_q   <= bad_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign value = value_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_thermo_seq_decoder.sv
// ============================================================================
// Module   : tb_thermo_seq_decoder
// Purpose  : Self-checking bench for thermo_seq_decoder (K=3, W=7); expected
//            results come from a reference model via a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thermo_seq_decoder;

  localparam int K = 3;
  localparam int W = 7;

  typedef struct {
    logic [K-1:0] value;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] code = '0;
  logic         busy, done, err;
  logic [K-1:0] value;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  thermo_seq_decoder #(.K(K), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .code  (code),
    .busy  (busy),
    .done  (done),
    .value (value),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] c);
    exp_t e;
    int   hi = -1;
    bit   zs = 1'b0;
    int   cnt = 0;
    e.err = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (c[i]) begin
        hi = i;
        if (zs) e.err = 1'b1;
        else    cnt++;
      end else begin
        zs = 1'b1;
      end
    end
    e.value = K'(cnt);
`ifdef THERMO_EARLY_EXIT_EN
    e.lat = (hi + 1) + 2;
    if (e.lat > W + 1) e.lat = W + 1;
`else
    e.lat = W + 1;
`endif
    return e;
  endfunction

  task automatic start_decode(input logic [W-1:0] c);
    @(negedge clk);
    code  = c;
    start = 1'b1;
    exp_q.push_back(model(c));
  endtask

  // Observes negedges after the start strobe; lat=0 means no done in budget.
  task automatic wait_done(output int lat, output int busy_cnt, output int overlap);
    lat = 0; busy_cnt = 0; overlap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && done) overlap++;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; code = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, value, err} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: busy=%b done=%b value=%0d err=%b, required all 0",
                 k, busy, done, value, err);
      end
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] tbl[6];
    int   lat, bc, ov;
    exp_t e;
    tbl[0] = 7'b0011111; tbl[1] = 7'b1111111; tbl[2] = 7'b0000000;
    tbl[3] = 7'b0001011; tbl[4] = 7'b1000000; tbl[5] = 7'b0000111;
    for (int t = 0; t < 6; t++) begin
      start_decode(tbl[t]);
      wait_done(lat, bc, ov);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty code=%b", tbl[t]);
        continue;
      end
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL latency code=%b: got %0d, required %0d", tbl[t], lat, e.lat);
      end
      checks++;
      if (value !== e.value || err !== e.err) begin
        errors++;
        $display("FAIL result code=%b: value=%0d err=%b, required value=%0d err=%b",
                 tbl[t], value, err, e.value, e.err);
      end
      checks++;
      if (bc !== e.lat - 1 || ov !== 0) begin
        errors++;
        $display("FAIL busy code=%b: busy cycles=%0d overlap=%0d, required %0d and 0",
                 tbl[t], bc, ov, e.lat - 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || value !== e.value || err !== e.err) begin
        errors++;
        $display("FAIL hold code=%b: done=%b busy=%b value=%0d err=%b, required 0 0 %0d %b",
                 tbl[t], done, busy, value, err, e.value, e.err);
      end
    end
  endtask

  task automatic test_start_ignored();
    int           ndone = 0, lat = 0, ov = 0;
    logic [K-1:0] v = '0;
    logic         e_bit = 1'b0;
    exp_t         e;
    start_decode(7'b0000011);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        code  = 7'b1111111;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy && done) ov++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = k; v = value; e_bit = err;
        end
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (ndone !== 1 || ov !== 0) begin
      errors++;
      $display("FAIL start_ignored: done pulses=%0d overlap=%0d, required 1 and 0", ndone, ov);
    end
    checks++;
    if (lat !== e.lat || v !== e.value || e_bit !== e.err) begin
      errors++;
      $display("FAIL start_ignored_result: lat=%0d value=%0d err=%b, required %0d %0d %b",
               lat, v, e_bit, e.lat, e.value, e.err);
    end
  endtask

  task automatic test_mid_reset();
    int   lat, bc, ov;
    exp_t e;
    start_decode(7'b1111111);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if ({busy, done, value, err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b value=%0d err=%b, required all 0",
               busy, done, value, err);
    end
    start_decode(7'b0000001);
    wait_done(lat, bc, ov);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat || value !== e.value || err !== e.err) begin
      errors++;
      $display("FAIL after_reset: lat=%0d value=%0d err=%b, required %0d %0d %b",
               lat, value, err, e.lat, e.value, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_start_ignored();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
